// File: rtl/mac_job_sequencer_pkg.sv
// Shared constants, FP16 field widths and FSM encoding for the MAC job sequencer.
// Optional exponent range handling is enabled with MAC_SEQ_EXC_EN.
package mac_job_sequencer_pkg;

  localparam int FP16_BIAS = 15;
  localparam int EXP_MAX   = 30;
  localparam int EXP_MIN   = 1;
  localparam int NORM_W    = 11;
  localparam int EXP_W     = 7;
  localparam int MANT_W    = 10;
  localparam int EF_W      = 5;
  localparam int FP16_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_OUT
  } seq_state_t;

endpackage

// File: rtl/mac_job_sequencer_fp16_pack.sv
// Packs stage-4 {sign, norm_sum, exp_final} into an FP16 word.
// MAC_SEQ_EXC_EN adds overflow-to-inf and flush-to-zero with flag outputs.
module mac_job_sequencer_fp16_pack
  import mac_job_sequencer_pkg::*;
(
  input  logic                    sign,
  input  logic [NORM_W-1:0]       norm,
  input  logic signed [EXP_W-1:0] exp,
`ifdef MAC_SEQ_EXC_EN
  output logic                    ovf,
  output logic                    unf,
`endif
  output logic [FP16_W-1:0]       word
);

  localparam logic signed [EXP_W:0] BIAS_E = (EXP_W+1)'(FP16_BIAS);

  logic signed [EXP_W:0] bexp;

  // one extra bit so exp+bias cannot wrap before the range check
  assign bexp = $signed({exp[EXP_W-1], exp}) + BIAS_E;

`ifdef MAC_SEQ_EXC_EN
  localparam logic signed [EXP_W:0] EMAX_E = (EXP_W+1)'(EXP_MAX);
  localparam logic signed [EXP_W:0] EMIN_E = (EXP_W+1)'(EXP_MIN);

  always_comb begin
    word = '0;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (norm == '0) begin
      word = {sign, 15'b0};
    end else if (bexp > EMAX_E) begin
      word = {sign, 5'h1F, 10'b0};
      ovf  = 1'b1;
    end else if (bexp < EMIN_E) begin
      word = {sign, 15'b0};
      unf  = 1'b1;
    end else begin
      word = {sign, bexp[EF_W-1:0], norm[MANT_W-1:0]};
    end
  end
`else
  logic unused_bexp_hi;
  assign unused_bexp_hi = ^bexp[EXP_W:EF_W];

  always_comb begin
    word = '0;
    if (norm == '0) begin
      word = {sign, 15'b0};
    end else begin
      word = {sign, bexp[EF_W-1:0], norm[MANT_W-1:0]};
    end
  end
`endif

endmodule

// File: rtl/mac_job_sequencer.sv
// Sequences one dot-product job through the non-stallable SD4 MAC pipeline.
// Define MAC_SEQ_EXC_EN for exponent overflow/underflow handling and flags.
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  input  logic [LEN_W-1:0]        job_len,
  output logic                    job_ready,
  input  logic                    op_valid,
  output logic                    op_ready,
  output logic                    pipe_vld,
  output logic                    pipe_first,
  output logic                    pipe_last,
  input  logic                    s4_sign,
  input  logic [NORM_W-1:0]       s4_norm,
  input  logic signed [EXP_W-1:0] s4_exp,
  output logic                    out_valid,
  output logic [FP16_W-1:0]       out_data,
`ifdef MAC_SEQ_EXC_EN
  output logic                    exc_ovf,
  output logic                    exc_unf,
`endif
  input  logic                    out_ready,
  output logic                    busy
);

  seq_state_t           state;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W-1:0]     cnt_inc;
  logic [PIPE_LAT-1:0]  tag;
  logic [FP16_W-1:0]    pk_word;

  assign job_ready  = (state == S_IDLE);
  assign op_ready   = (state == S_FEED);
  assign busy       = (state != S_IDLE);
  assign cnt_inc    = cnt + LEN_W'(1);
  assign pipe_vld   = op_valid & op_ready;
  assign pipe_first = pipe_vld & (cnt == '0);
  assign pipe_last  = pipe_vld & (cnt_inc == len_q);

`ifdef MAC_SEQ_EXC_EN
  logic pk_ovf;
  logic pk_unf;
`endif

  mac_job_sequencer_fp16_pack u_pack (
    .sign (s4_sign),
    .norm (s4_norm),
    .exp  (s4_exp),
`ifdef MAC_SEQ_EXC_EN
    .ovf  (pk_ovf),
    .unf  (pk_unf),
`endif
    .word (pk_word)
  );

  // tag pipe mirrors the datapath: a last tag leaves it with the stage-4 result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
    end else begin
      tag[0] <= pipe_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef MAC_SEQ_EXC_EN
      exc_ovf   <= 1'b0;
      exc_unf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (job_valid) begin
            len_q <= job_len;
            cnt   <= '0;
            if (job_len == '0) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= '0;
`ifdef MAC_SEQ_EXC_EN
              exc_ovf   <= 1'b0;
              exc_unf   <= 1'b0;
`endif
            end else begin
              state <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (pipe_vld) begin
            cnt <= cnt_inc;
            if (pipe_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tag[PIPE_LAT-1]) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_data  <= pk_word;
`ifdef MAC_SEQ_EXC_EN
            exc_ovf   <= pk_ovf;
            exc_unf   <= pk_unf;
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
`ifdef MAC_SEQ_EXC_EN
            exc_ovf   <= 1'b0;
            exc_unf   <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Randomized self-checking bench for mac_job_sequencer against a job-level model.
// Build with MAC_SEQ_EXC_EN to also cover the exception ports.
module tb_mac_job_sequencer;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              job_valid = 1'b0;
  logic [LEN_W-1:0]  job_len = '0;
  logic              job_ready;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic              pipe_vld;
  logic              pipe_first;
  logic              pipe_last;
  logic              s4_sign = 1'b0;
  logic [10:0]       s4_norm = '0;
  logic signed [6:0] s4_exp = '0;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready = 1'b0;
  logic              busy;
`ifdef MAC_SEQ_EXC_EN
  logic              exc_ovf;
  logic              exc_unf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mac_job_sequencer #(
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_len    (job_len),
    .job_ready  (job_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .pipe_vld   (pipe_vld),
    .pipe_first (pipe_first),
    .pipe_last  (pipe_last),
    .s4_sign    (s4_sign),
    .s4_norm    (s4_norm),
    .s4_exp     (s4_exp),
    .out_valid  (out_valid),
    .out_data   (out_data),
`ifdef MAC_SEQ_EXC_EN
    .exc_ovf    (exc_ovf),
    .exc_unf    (exc_unf),
`endif
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // FP16 value the result should carry, from the packing rules
  function automatic logic [15:0] ref_pack(input logic s, input logic [10:0] n,
                                           input logic [6:0] e,
                                           output logic ov, output logic un);
    int be;
    be = int'($signed(e)) + 15;
    ov = 1'b0;
    un = 1'b0;
    if (n == 11'd0) return {s, 15'b0};
`ifdef MAC_SEQ_EXC_EN
    if (be > 30) begin
      ov = 1'b1;
      return {s, 5'h1F, 10'b0};
    end
    if (be < 1) begin
      un = 1'b1;
      return {s, 15'b0};
    end
`endif
    return {s, 5'(be), n[9:0]};
  endfunction

  task automatic rand_s4();
    s4_sign = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       s4_norm = '0;
      1:       s4_norm = 11'($urandom);
      default: s4_norm = {1'b1, 10'($urandom)};
    endcase
    if ($urandom_range(0, 3) == 0) s4_exp = 7'($urandom);
    else s4_exp = 7'($urandom_range(0, 40) - 20);
  endtask

  task automatic run_job(input int len, input int pct, input logic use_pat,
                         input logic [15:0] pat, input logic force_s4,
                         input logic [18:0] s4v, input int hold,
                         input int exp_last);
    int acc, k, first_k, last_k;
    logic ov, e_ovf, e_unf;
    logic [15:0] exp_d;
    next_cyc();
    job_valid = 1'b1;
    job_len   = LEN_W'(len);
    op_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    rand_s4();
    #1;
    chk("idle_job_ready", 32'(job_ready), 32'd1);
    chk("idle_pipe_vld", 32'(pipe_vld), 32'd0);
    acc = 0; k = 0; first_k = 0; last_k = 0;
    exp_d = '0; e_ovf = 1'b0; e_unf = 1'b0;
    while (acc < len) begin
      next_cyc();
      k++;
      job_valid = 1'($urandom);
      job_len   = LEN_W'($urandom);
      out_ready = 1'($urandom);
      if (use_pat) ov = (k > 16) ? 1'b1 : pat[k-1];
      else ov = ($urandom_range(1, 100) <= pct);
      op_valid = ov;
      rand_s4();
      #1;
      chk("feed_op_ready", 32'(op_ready), 32'd1);
      chk("feed_pipe_vld", 32'(pipe_vld), 32'(ov));
      chk("feed_first", 32'(pipe_first), 32'(ov && acc == 0));
      chk("feed_last", 32'(pipe_last), 32'(ov && acc == len - 1));
      chk("feed_out_valid", 32'(out_valid), 32'd0);
      if (ov) begin
        if (acc == 0) first_k = k;
        acc++;
        last_k = k;
      end
      if (k > 2000) begin
        chk("feed_timeout", 32'(k), 32'd0);
        break;
      end
    end
    if (exp_last > 0) begin
      chk("first_cycle", 32'(first_k), 32'd1);
      chk("last_cycle", 32'(last_k), 32'(exp_last));
    end
    if (len > 0) begin
      for (int d = 1; d <= PIPE_LAT; d++) begin
        next_cyc();
        job_valid = 1'($urandom);
        op_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        rand_s4();
        if (d == PIPE_LAT && force_s4) {s4_sign, s4_norm, s4_exp} = s4v;
        #1;
        chk("drain_op_ready", 32'(op_ready), 32'd0);
        chk("drain_pipe_vld", 32'(pipe_vld), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        if (d == PIPE_LAT) exp_d = ref_pack(s4_sign, s4_norm, s4_exp, e_ovf, e_unf);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      next_cyc();
      job_valid = 1'($urandom);
      op_valid  = 1'b1;
      out_ready = (h == hold);
      rand_s4();
      #1;
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", 32'(out_data), 32'(exp_d));
      chk("out_job_ready", 32'(job_ready), 32'd0);
      chk("out_pipe_vld", 32'(pipe_vld), 32'd0);
`ifdef MAC_SEQ_EXC_EN
      chk("out_exc_ovf", 32'(exc_ovf), 32'(e_ovf));
      chk("out_exc_unf", 32'(exc_unf), 32'(e_unf));
`endif
    end
    next_cyc();
    job_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("done_out_valid", 32'(out_valid), 32'd0);
    chk("done_job_ready", 32'(job_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_drain();
    next_cyc();
    job_valid = 1'b1;
    job_len   = LEN_W'(5);
    op_valid  = 1'b1;
    #1;
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    for (int i = 0; i < 5 + 2; i++) begin
      next_cyc();
      job_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idle", 32'(job_ready), 32'd1);
    next_cyc();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      #1;
      chk("rst_no_result", 32'(out_valid), 32'd0);
      chk("rst_stay_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    op_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_job_ready", 32'(job_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_op_ready", 32'(op_ready), 32'd0);
    chk("reset_pipe_vld", 32'(pipe_vld), 32'd0);
`ifdef MAC_SEQ_EXC_EN
    chk("reset_exc_ovf", 32'(exc_ovf), 32'd0);
    chk("reset_exc_unf", 32'(exc_unf), 32'd0);
`endif
    rst = 1'b1;
    op_valid = 1'b0;

    run_job(3, 100, 1'b0, 16'd0, 1'b1, {1'b0, 11'h400, 7'd0}, 0, 3);
    run_job(4, 0, 1'b1, 16'b110101, 1'b1, {1'b1, 11'h600, 7'd1}, 0, 6);
    run_job(0, 100, 1'b0, 16'd0, 1'b0, 19'd0, 0, 0);
    run_job(2, 100, 1'b0, 16'd0, 1'b0, 19'd0, 5, 0);
    run_job(1, 100, 1'b0, 16'd0, 1'b1, {1'b0, 11'h400, 7'd16}, 0, 1);
    run_job(2, 100, 1'b0, 16'd0, 1'b1, {1'b1, 11'h5A5, 7'h60}, 1, 0);
    reset_mid_drain();
    for (int j = 0; j < 40; j++) begin
      run_job($urandom_range(0, 20), $urandom_range(30, 100), 1'b0, 16'd0,
              1'b0, 19'd0, $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
